// File: rtl/dkstr_pkg.sv
// Shared definitions for the pathfinding array: direction codes, cost sentinels,
// tracer state encoding and per-direction unit deltas.
// Pure declarations; no logic and no latency of its own.
package dkstr_pkg;

  // Predecessor direction codes, clockwise from north
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  // Cost sentinels written by the relaxation array
  localparam logic [15:0] COST_INF = 16'hFFFF;
  localparam logic [15:0] COST_SRC = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EVAL = 3'd3,
    ST_EMIT = 3'd4,
    ST_FIN  = 3'd5
  } tracer_state_e;

  // Two's-complement x delta (-1/0/+1) for a direction; east is positive
  function automatic logic [1:0] dir_dx(input logic [2:0] dir);
    logic [1:0] d;
    d = 2'b00;
    if (dir == DIR_NE || dir == DIR_E || dir == DIR_SE) d = 2'b01;
    if (dir == DIR_SW || dir == DIR_W || dir == DIR_NW) d = 2'b11;
    return d;
  endfunction

  // Two's-complement y delta (-1/0/+1) for a direction; south is positive
  function automatic logic [1:0] dir_dy(input logic [2:0] dir);
    logic [1:0] d;
    d = 2'b00;
    if (dir == DIR_NW || dir == DIR_N || dir == DIR_NE) d = 2'b11;
    if (dir == DIR_SE || dir == DIR_S || dir == DIR_SW) d = 2'b01;
    return d;
  endfunction

endpackage

// File: rtl/path_tracer_if.sv
// Node read port plus step output stream of the path tracer.
// No logic; the read port has one-cycle latency, the step stream is valid/ready.
// master = tracer side, slave = grid memory / step consumer side.
interface path_tracer_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  // Node read port
  logic              rd_en;
  logic [X_BITS-1:0] rd_x;
  logic [Y_BITS-1:0] rd_y;
  logic [15:0]       rd_cost;
  logic [2:0]        rd_dir;

  // Step stream
  logic              step_valid;
  logic              step_ready;
  logic [X_BITS-1:0] step_x;
  logic [Y_BITS-1:0] step_y;
  logic [2:0]        step_dir;
  logic              step_last;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_cost, rd_dir,
    output step_valid, step_x, step_y, step_dir, step_last,
    input  step_ready
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_cost, rd_dir,
    input  step_valid, step_x, step_y, step_dir, step_last,
    output step_ready
  );

endinterface

// File: rtl/path_tracer_dir_step.sv
// Grid walker helper: neighbour coordinate of (x,y) in a direction, with out-of-grid flag.
// Purely combinational, zero latency.
// No backpressure; result is valid whenever the inputs are.
module dir_step
  import dkstr_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic [X_BITS-1:0] cur_x_i,
  input  logic [Y_BITS-1:0] cur_y_i,
  input  logic [2:0]        dir_i,
  output logic [X_BITS-1:0] nxt_x_o,
  output logic [Y_BITS-1:0] nxt_y_o,
  output logic              out_of_grid_o
);

  // One extra bit so that both -1 and GRID_W/GRID_H are representable
  localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(GRID_W);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(GRID_H);

  logic [1:0]      dx, dy;
  logic [X_BITS:0] ext_x;
  logic [Y_BITS:0] ext_y;

  // Sign-extended add of the unit delta; a set MSB means the walk left the grid
  // (either below zero, or past 2^BITS-1 when the grid fills the coordinate space)
  always_comb begin
    dx            = dir_dx(dir_i);
    dy            = dir_dy(dir_i);
    ext_x         = {1'b0, cur_x_i} + {{(X_BITS-1){dx[1]}}, dx};
    ext_y         = {1'b0, cur_y_i} + {{(Y_BITS-1){dy[1]}}, dy};
    nxt_x_o       = ext_x[X_BITS-1:0];
    nxt_y_o       = ext_y[Y_BITS-1:0];
    out_of_grid_o = ext_x[X_BITS] || (ext_x >= X_LIM) ||
                    ext_y[Y_BITS] || (ext_y >= Y_LIM);
  end

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor chain from a goal node back to the source, one step per node.
// Latency: start->first step_valid 4 cycles; handshake->next step_valid 4 cycles.
// Holds step_* stable while step_ready is low; optional abort via PATH_TRACER_ABORT_EN.
module path_tracer
  import dkstr_pkg::*;
#(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int X_BITS    = 4,
  parameter int Y_BITS    = 4,
  parameter int MAX_STEPS = GRID_W * GRID_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [X_BITS-1:0] goal_x,
  input  logic [Y_BITS-1:0] goal_y,
`ifdef PATH_TRACER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  path_tracer_if.master     bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_READ = ST_READ;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_EVAL = ST_EVAL;
  localparam logic [2:0] S_EMIT = ST_EMIT;
  localparam logic [2:0] S_FIN  = ST_FIN;

  localparam int              CNT_W    = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STEPS - 1);
  localparam logic [X_BITS:0] X_LIM    = (X_BITS+1)'(GRID_W);
  localparam logic [Y_BITS:0] Y_LIM    = (Y_BITS+1)'(GRID_H);

  logic [2:0]        state_q, state_d;
  logic [X_BITS-1:0] cur_x_q, cur_x_d;
  logic [Y_BITS-1:0] cur_y_q, cur_y_d;
  logic [15:0]       cost_q, cost_d;
  logic [2:0]        dir_q, dir_d;
  logic [X_BITS-1:0] step_x_q, step_x_d;
  logic [Y_BITS-1:0] step_y_q, step_y_d;
  logic [2:0]        step_dir_q, step_dir_d;
  logic              step_last_q, step_last_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [X_BITS-1:0] nxt_x;
  logic [Y_BITS-1:0] nxt_y;
  logic              nxt_oog;
  logic              goal_oog;
  logic              abort_req;

  dir_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_dir_step (
    .cur_x_i       (cur_x_q),
    .cur_y_i       (cur_y_q),
    .dir_i         (dir_q),
    .nxt_x_o       (nxt_x),
    .nxt_y_o       (nxt_y),
    .out_of_grid_o (nxt_oog)
  );

  // Abort only cuts a live trace short; IDLE and FIN are left alone
`ifdef PATH_TRACER_ABORT_EN
  assign abort_req = abort && (state_q != S_IDLE) && (state_q != S_FIN);
`else
  assign abort_req = 1'b0;
`endif

  assign goal_oog = ({1'b0, goal_x} >= X_LIM) || ({1'b0, goal_y} >= Y_LIM);

  // Trace sequencing: read node, evaluate its cost, emit it, step to predecessor
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cost_d      = cost_q;
    dir_d       = dir_q;
    step_x_d    = step_x_q;
    step_y_d    = step_y_q;
    step_dir_d  = step_dir_q;
    step_last_d = step_last_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_x_d = goal_x;
          cur_y_d = goal_y;
          cnt_d   = '0;
          err_d   = goal_oog;
          state_d = goal_oog ? S_FIN : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        cost_d  = bus.rd_cost;
        dir_d   = bus.rd_dir;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cost_q == COST_INF) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          step_x_d    = cur_x_q;
          step_y_d    = cur_y_q;
          step_dir_d  = dir_q;
          step_last_d = (cost_q == COST_SRC);
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.step_ready) begin
          if (step_last_q) begin
            state_d = S_FIN;
          end else if (nxt_oog) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (cnt_q == CNT_LAST) begin
            // Step budget exhausted: the chain must contain a cycle
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            cur_x_d = nxt_x;
            cur_y_d = nxt_y;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_req) begin
      err_d   = 1'b1;
      state_d = S_FIN;
    end
  end

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cost_q      <= '0;
      dir_q       <= '0;
      step_x_q    <= '0;
      step_y_q    <= '0;
      step_dir_q  <= '0;
      step_last_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cost_q      <= cost_d;
      dir_q       <= dir_d;
      step_x_q    <= step_x_d;
      step_y_q    <= step_y_d;
      step_dir_q  <= step_dir_d;
      step_last_q <= step_last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign err            = (state_q == S_FIN) && err_q;
  assign bus.rd_en      = (state_q == S_READ);
  assign bus.rd_x       = cur_x_q;
  assign bus.rd_y       = cur_y_q;
  assign bus.step_valid = (state_q == S_EMIT);
  assign bus.step_x     = step_x_q;
  assign bus.step_y     = step_y_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.step_last  = step_last_q;

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer on a 4x4 grid with an 8-step budget.
// A small array model answers node reads one cycle after rd_en.
// Outputs are sampled on the falling edge; step_ready is driven there too.
module tb_path_tracer;

  localparam int GW = 4;
  localparam int GH = 4;
  localparam int XB = 3;
  localparam int YB = 3;
  localparam int MS = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [XB-1:0] goal_x;
  logic [YB-1:0] goal_y;
  logic          busy, done, err;
`ifdef PATH_TRACER_ABORT_EN
  logic          abort;
`endif

  path_tracer_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();

  path_tracer #(
    .GRID_W(GW), .GRID_H(GH), .X_BITS(XB), .Y_BITS(YB), .MAX_STEPS(MS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .goal_x (goal_x),
    .goal_y (goal_y),
`ifdef PATH_TRACER_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Grid memory model
  logic [15:0] cost_m [GW][GH];
  logic [2:0]  dir_m  [GW][GH];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      if (int'(bus.rd_x) < GW && int'(bus.rd_y) < GH) begin
        bus.rd_cost <= cost_m[int'(bus.rd_x)][int'(bus.rd_y)];
        bus.rd_dir  <= dir_m[int'(bus.rd_x)][int'(bus.rd_y)];
      end else begin
        bus.rd_cost <= 16'hFFFF;
        bus.rd_dir  <= 3'd0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic grid_clear();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) begin
        cost_m[x][y] = 16'hFFFF;
        dir_m[x][y]  = 3'd0;
      end
  endtask

  task automatic set_node(input int x, input int y, input int c, input int d);
    cost_m[x][y] = 16'(c);
    dir_m[x][y]  = 3'(d);
  endtask

  // Per-trace observations (cycles relative to the start-accept cycle)
  int hs_n, rd_n, rd_while_vld, err_no_done, first_vld, done_cyc, done_err;
  int hs_x [16];
  int hs_y [16];
  int hs_d [16];
  int hs_l [16];
  int hs_c [16];
  int rd_ax [16];
  int rd_ay [16];

  task automatic run_trace(input int gx, input int gy, input int stall_idx,
                           input int stall_len, input int busy_ofs);
    int t0, stall_cnt, sx, sy, sd;
    bit fin;
    hs_n = 0; rd_n = 0; rd_while_vld = 0; err_no_done = 0;
    first_vld = -1; done_cyc = -1; done_err = -1;
    stall_cnt = 0; sx = 0; sy = 0; sd = 0; fin = 0;
    @(negedge clk);
    goal_x = XB'(gx);
    goal_y = YB'(gy);
    start = 1'b1;
    bus.step_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy_ofs > 0 && cyc == t0 + busy_ofs) begin
        start = 1'b1; goal_x = 3'd3; goal_y = 3'd3;
      end
      if (bus.rd_en) begin
        if (rd_n < 16) begin rd_ax[rd_n] = int'(bus.rd_x); rd_ay[rd_n] = int'(bus.rd_y); end
        rd_n++;
        if (bus.step_valid) rd_while_vld++;
      end
      if (err && !done) err_no_done++;
      if (bus.step_valid && first_vld < 0) first_vld = cyc - t0;
      if (done) begin done_cyc = cyc - t0; done_err = int'(err); fin = 1; end
      if (bus.step_valid && hs_n == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          sx = int'(bus.step_x); sy = int'(bus.step_y); sd = int'(bus.step_dir);
        end else begin
          check("stall_x",   int'(bus.step_x),   sx);
          check("stall_y",   int'(bus.step_y),   sy);
          check("stall_dir", int'(bus.step_dir), sd);
        end
        bus.step_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.step_ready = 1'b1;
      end
      if (bus.step_valid && bus.step_ready) begin
        if (hs_n < 16) begin
          hs_x[hs_n] = int'(bus.step_x);   hs_y[hs_n] = int'(bus.step_y);
          hs_d[hs_n] = int'(bus.step_dir); hs_l[hs_n] = int'(bus.step_last);
          hs_c[hs_n] = cyc - t0;
        end
        hs_n++;
      end
    end
    start = 1'b0;
    bus.step_ready = 1'b1;
    if (!fin) check("trace_timeout", 0, 1);
    check("err_without_done", err_no_done, 0);
  endtask

  task automatic straight_grid();
    grid_clear();
    set_node(3, 0, 6, 6);
    set_node(2, 0, 4, 6);
    set_node(1, 0, 2, 6);
    set_node(0, 0, 0, 0);
  endtask

  int exp_c;

  initial begin
    rst = 1'b1; start = 1'b0; goal_x = '0; goal_y = '0;
    bus.step_ready = 1'b1; bus.rd_cost = '0; bus.rd_dir = '0;
`ifdef PATH_TRACER_ABORT_EN
    abort = 1'b0;
`endif
    grid_clear();
    repeat (3) @(negedge clk);
    check("reset_ctrl", int'({busy, done, err, bus.rd_en, bus.step_valid, bus.step_last}), 0);
    check("reset_addr", int'({bus.rd_x, bus.rd_y, bus.step_x, bus.step_y, bus.step_dir}), 0);
    rst = 1'b0;

    // Straight path west along row 0
    straight_grid();
    run_trace(3, 0, 99, 0, 0);
    check("straight_first_vld", first_vld, 4);
    check("straight_steps", hs_n, 4);
    check("straight_reads", rd_n, 4);
    for (int i = 0; i < 4; i++) begin
      check("straight_x",    hs_x[i], 3 - i);
      check("straight_y",    hs_y[i], 0);
      check("straight_dir",  hs_d[i], (i == 3) ? 0 : 6);
      check("straight_last", hs_l[i], (i == 3) ? 1 : 0);
      check("straight_hs_cyc", hs_c[i], 4 + 4 * i);
      check("straight_rd_x", rd_ax[i], 3 - i);
    end
    check("straight_done_cyc", done_cyc, 17);
    check("straight_err", done_err, 0);

    // Diagonal path, started back-to-back two cycles after the last handshake
    grid_clear();
    set_node(2, 2, 4, 7);
    set_node(1, 1, 2, 7);
    set_node(0, 0, 0, 0);
    run_trace(2, 2, 99, 0, 0);
    check("diag_first_vld", first_vld, 4);
    check("diag_steps", hs_n, 3);
    for (int i = 0; i < 3; i++) begin
      check("diag_x", hs_x[i], 2 - i);
      check("diag_y", hs_y[i], 2 - i);
      check("diag_last", hs_l[i], (i == 2) ? 1 : 0);
    end
    check("diag_done_cyc", done_cyc, hs_c[2] + 1);
    check("diag_err", done_err, 0);

    // Unreachable goal
    grid_clear();
    run_trace(1, 2, 99, 0, 0);
    check("unreach_steps", hs_n, 0);
    check("unreach_first_vld", first_vld, -1);
    check("unreach_reads", rd_n, 1);
    check("unreach_done_cyc", done_cyc, 4);
    check("unreach_err", done_err, 1);

    // Backpressure on the second step for five cycles
    straight_grid();
    run_trace(3, 0, 1, 5, 0);
    check("bp_steps", hs_n, 4);
    check("bp_reads", rd_n, 4);
    check("bp_rd_while_vld", rd_while_vld, 0);
    check("bp_hs1_cyc", hs_c[1], 13);
    check("bp_step2_x", hs_x[1], 2);
    check("bp_hs3_cyc", hs_c[3], 21);
    check("bp_done_cyc", done_cyc, 22);
    check("bp_err", done_err, 0);

    // Two-node loop exhausts the step budget
    grid_clear();
    set_node(1, 1, 5, 2);
    set_node(2, 1, 5, 6);
    run_trace(1, 1, 99, 0, 0);
    check("loop_steps", hs_n, MS);
    for (int i = 0; i < MS; i++) begin
      check("loop_x", hs_x[i], (i % 2 == 0) ? 1 : 2);
      check("loop_last", hs_l[i], 0);
    end
    check("loop_done_cyc", done_cyc, 4 * MS + 1);
    check("loop_err", done_err, 1);

    // Predecessor direction points off the north edge
    grid_clear();
    set_node(0, 0, 3, 0);
    run_trace(0, 0, 99, 0, 0);
    check("oog_dir_steps", hs_n, 1);
    check("oog_dir_done_cyc", done_cyc, 5);
    check("oog_dir_err", done_err, 1);

    // Goal outside the grid
    run_trace(4, 0, 99, 0, 0);
    check("oog_goal_reads", rd_n, 0);
    check("oog_goal_done_cyc", done_cyc, 1);
    check("oog_goal_err", done_err, 1);

    // Goal is the source; a second start during the trace is ignored
    grid_clear();
    set_node(2, 3, 0, 5);
    run_trace(2, 3, 99, 0, 2);
    check("src_steps", hs_n, 1);
    check("src_last", hs_l[0], 1);
    check("src_xy", hs_x[0] * 4 + hs_y[0], 11);
    check("src_reads", rd_n, 1);
    check("src_done_cyc", done_cyc, 5);
    check("src_err", done_err, 0);
    repeat (3) @(negedge clk);
    check("src_idle_after", int'(busy), 0);

    // Reset while a step is waiting in EMIT
    straight_grid();
    @(negedge clk);
    goal_x = 3'd3; goal_y = 3'd0; start = 1'b1; bus.step_ready = 1'b0;
    exp_c = 0;
    for (int k = 0; k < 10 && !bus.step_valid; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_pre_valid", int'(bus.step_valid), 1);
    check("rst_pre_x", int'(bus.step_x), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ctrl", int'({busy, done, err, bus.rd_en, bus.step_valid, bus.step_last}), 0);
    check("rst_mid_addr", int'({bus.rd_x, bus.rd_y, bus.step_x, bus.step_y, bus.step_dir}), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy) exp_c++;
    end
    check("rst_no_done", exp_c, 0);
    bus.step_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
